prim_pad_in_filter: RTL and testbench
=====================================

Name: prim_pad_in_filter

Overview:
- Sits directly downstream of the FPGA/ASIC pad wrapper.
- Consumes the asynchronous, already-inverted pad input bits and synchronizes them into the core clock domain.
- Removes glitches with a programmable per-pad stability counter.
- Produces a filtered level, single-cycle rise/fall pulses, and sticky event flags for the GPIO/peripheral logic.

Parameters:
- NumPads, 4, number of independent pad input channels.
- CntWidth, 8, width of the stability counter and of thresh_i.

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  synchronous active-low reset.
- pad_i  input  NumPads  asynchronous pad input levels (pad wrapper in_o).
- en_i  input  NumPads  per-pad filter enable.
- thresh_i  input  CntWidth  shared stability threshold T; quasi-static.
- clr_i  input  NumPads  per-pad clear of sticky event flags.
- filt_o  output  NumPads  filtered, synchronized level.
- rise_o  output  NumPads  one-cycle pulse on a 0->1 filtered transition.
- fall_o  output  NumPads  one-cycle pulse on a 1->0 filtered transition.
- evt_rise_o  output  NumPads  sticky rise-seen flag.
- evt_fall_o  output  NumPads  sticky fall-seen flag.

Behaviour:
- Reset: all flops clear on the clk_i edge while rst_ni=0. This covers sync stages s1/s2, filt_o, cnt, state=IDLE, rise_o, fall_o, evt_rise_o and evt_fall_o, all set to 0.
- Synchronizer: per pad, s1<=pad_i and s2<=s1 every cycle, independent of en_i. No logic is permitted between s1 and s2.
- Per-pad FSM has two states, IDLE and COUNT. All outputs are registered.
  - IDLE, s2==filt: cnt stays 0.
  - IDLE, s2!=filt: if T==0, update filt now. Otherwise cnt<=1 and go to COUNT.
  - COUNT, s2==filt (glitch ended): cnt<=0, go to IDLE, filt unchanged, no pulse.
  - COUNT, s2!=filt and cnt>=T: filt<=s2, cnt<=0, go to IDLE.
  - COUNT, s2!=filt and cnt<T: cnt<=cnt+1.
- Update: when filt changes, rise_o or fall_o is high for exactly that one cycle, aligned with the new filt_o value. Otherwise both are 0.
- Latency: a level change on pad_i held stable reaches filt_o at clock edge 3+T, counted from the first sampling edge as edge 1. With T=0 the block is a pure 2-flop synchronizer plus an output register.
- Glitch rejection: any input excursion whose s2 image lasts <=T cycles never changes filt_o.
- Counter width: cnt is CntWidth bits and never exceeds T, so no wrap is possible. T=2^CntWidth-1 is legal.
- Threshold change mid-count: the comparison is >=. If T drops below the current cnt, the update occurs on the next edge where s2!=filt.
- en_i[i]=0:
  - Forces cnt<=0 and state IDLE; filt_o holds.
  - rise_o and fall_o stay 0; the sticky flags hold, and clr_i still clears them.
  - Re-enable resumes from IDLE against the held filt value.
- Sticky flags: evt_rise set by rise_o and cleared by clr_i. If a set and a clear occur in the same cycle, set wins. evt_fall uses identical rules.
- Reset mid-count: count abandoned; filt_o returns to 0 regardless of pad level. After release, a pad held at 1 produces a rise after 3+T edges.
- Pads are fully independent. Simultaneous events on different pads are all reported in the same cycle.

Test Plan:
- Reset, T=4, en=all-1, pad_i[0] 0->1 held: filt_o[0] rises on edge 7. rise_o[0] is a single pulse on edge 7. evt_rise_o[0]=1 until clr_i[0] is pulsed, then 0 on the next edge.
- T=4, 3-cycle-wide 1-pulse on pad_i[1]: filt_o[1], rise_o[1] and fall_o[1] stay 0 throughout. A 6-cycle pulse yields a rise at edge 7 and a fall 6 cycles later.
- T=0: pad_i[2] toggles every 4 cycles. filt_o[2] follows with a 3-edge delay, with one rise/fall pulse per toggle.
- T=200 with pad_i[3]=1 held: deassert en_i[3] at count 100 and hold for 5 cycles, then re-enable. filt_o[3] rises exactly 201 cycles after re-enable plus 1, with no pulse while disabled.
- Same-cycle clr_i[0]=1 and rise_o[0]=1: evt_rise_o[0]=1 afterwards. Assert rst_ni=0 mid-count on all pads: every output is 0 on the next edge.
- T=255 (CntWidth=8 maximum): a stable level is accepted after 258 edges, and cnt never exceeds 255 (checked by assertion).

Source files
------------

// File: rtl/prim_pad_in_filter.sv
// Pad input conditioner: 2-flop synchronizer, per-pad stability filter,
// registered level/edge outputs and sticky edge-event flags.
module prim_pad_in_filter #(
  parameter int NumPads  = 4,
  parameter int CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPads-1:0]  pad_i,
  input  logic [NumPads-1:0]  en_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic [NumPads-1:0]  clr_i,
  output logic [NumPads-1:0]  filt_o,
  output logic [NumPads-1:0]  rise_o,
  output logic [NumPads-1:0]  fall_o,
  output logic [NumPads-1:0]  evt_rise_o,
  output logic [NumPads-1:0]  evt_fall_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  logic [NumPads-1:0]  s1_p0;
  logic [NumPads-1:0]  s2_p1;
  state_e              state_p2  [NumPads];
  state_e              state_nxt [NumPads];
  logic [CntWidth-1:0] cnt_p2    [NumPads];
  logic [CntWidth-1:0] cnt_nxt   [NumPads];
  logic [NumPads-1:0]  filt_nxt;
  logic [NumPads-1:0]  rise_nxt;
  logic [NumPads-1:0]  fall_nxt;
  logic [NumPads-1:0]  evt_rise_nxt;
  logic [NumPads-1:0]  evt_fall_nxt;

  // Saturating increment; the >= compare normally stops the count first.
  function automatic logic [CntWidth-1:0] cnt_inc(input logic [CntWidth-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Filter decision stage: compare synchronized level against held level
  always_comb begin
    for (int i = 0; i < NumPads; i++) begin
      state_nxt[i] = state_p2[i];
      cnt_nxt[i]   = cnt_p2[i];
      filt_nxt[i]  = filt_o[i];
      if (!en_i[i] || (s2_p1[i] == filt_o[i])) begin
        state_nxt[i] = IDLE;
        cnt_nxt[i]   = '0;
      end else if (state_p2[i] == IDLE) begin
        if (thresh_i == '0) begin
          filt_nxt[i] = s2_p1[i];
        end else begin
          cnt_nxt[i]   = CntWidth'(1);
          state_nxt[i] = COUNT;
        end
      end else if (cnt_p2[i] >= thresh_i) begin
        filt_nxt[i]  = s2_p1[i];
        cnt_nxt[i]   = '0;
        state_nxt[i] = IDLE;
      end else begin
        cnt_nxt[i] = cnt_inc(cnt_p2[i]);
      end
    end
  end

  assign rise_nxt     = filt_nxt & ~filt_o;
  assign fall_nxt     = ~filt_nxt & filt_o;
  // Set has priority over clear in the same cycle.
  assign evt_rise_nxt = rise_o | (evt_rise_o & ~clr_i);
  assign evt_fall_nxt = fall_o | (evt_fall_o & ~clr_i);

  // Register stage: synchronizer pair, filter state and all outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_p0      <= '0;
      s2_p1      <= '0;
      filt_o     <= '0;
      rise_o     <= '0;
      fall_o     <= '0;
      evt_rise_o <= '0;
      evt_fall_o <= '0;
      for (int i = 0; i < NumPads; i++) begin
        state_p2[i] <= IDLE;
        cnt_p2[i]   <= '0;
      end
    end else begin
      s1_p0      <= pad_i;
      s2_p1      <= s1_p0;
      filt_o     <= filt_nxt;
      rise_o     <= rise_nxt;
      fall_o     <= fall_nxt;
      evt_rise_o <= evt_rise_nxt;
      evt_fall_o <= evt_fall_nxt;
      for (int i = 0; i < NumPads; i++) begin
        state_p2[i] <= state_nxt[i];
        cnt_p2[i]   <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_prim_pad_in_filter.sv
// Bench for prim_pad_in_filter: directed scenarios plus random traffic,
// checked every cycle against a run-length reference model.
module tb_prim_pad_in_filter;
  localparam int NP = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] pad, en, clr;
  logic [CW-1:0] thresh;
  logic [NP-1:0] filt, rise, fall, evt_rise, evt_fall;

  int tests = 0;
  int fails = 0;

  // Reference model: level changes once s2 has differed for T+1 enabled edges
  logic [NP-1:0] m_s1, m_s2, m_filt, m_rise, m_fall, m_er, m_ef;
  int            m_run [NP];

  always #5 clk = ~clk;

  prim_pad_in_filter #(.NumPads(NP), .CntWidth(CW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pad_i      (pad),
    .en_i       (en),
    .thresh_i   (thresh),
    .clr_i      (clr),
    .filt_o     (filt),
    .rise_o     (rise),
    .fall_o     (fall),
    .evt_rise_o (evt_rise),
    .evt_fall_o (evt_fall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [NP-1:0] nf;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_filt = '0; m_rise = '0; m_fall = '0;
      m_er = '0; m_ef = '0;
      for (int i = 0; i < NP; i++) m_run[i] = 0;
    end else begin
      m_er = m_rise | (m_er & ~clr);
      m_ef = m_fall | (m_ef & ~clr);
      nf = m_filt;
      for (int i = 0; i < NP; i++) begin
        if (en[i] && (m_s2[i] != m_filt[i])) begin
          m_run[i]++;
          if (m_run[i] > int'(thresh)) begin
            nf[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_rise = nf & ~m_filt;
      m_fall = ~nf & m_filt;
      m_filt = nf;
      m_s2 = m_s1;
      m_s1 = pad;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("filt", 32'(filt), 32'(m_filt));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("evt_rise", 32'(evt_rise), 32'(m_er));
    chk("evt_fall", 32'(evt_fall), 32'(m_ef));
    for (int i = 0; i < NP; i++)
      chk("cnt_le_T", 32'(dut.cnt_p2[i] <= thresh), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [NP-1:0] seen;
    logic          hist [$];
    int            nr, nf;

    rst_n = 1'b0; pad = '0; en = '1; clr = '0; thresh = 8'd4;
    tick(); tick();
    chk("reset_outs", 32'({filt, rise, fall, evt_rise, evt_fall}), 32'd0);

    // T=4 rise on pad 0 lands on edge 7, sticky flag until cleared
    rst_n = 1'b1; pad[0] = 1'b1;
    repeat (6) tick();
    chk("t1_filt_e6", 32'(filt[0]), 32'd0);
    tick();
    chk("t1_filt_e7", 32'(filt[0]), 32'd1);
    chk("t1_rise_e7", 32'(rise[0]), 32'd1);
    tick();
    chk("t1_rise_e8", 32'(rise[0]), 32'd0);
    chk("t1_evt_set", 32'(evt_rise[0]), 32'd1);
    repeat (3) tick();
    chk("t1_evt_hold", 32'(evt_rise[0]), 32'd1);
    clr[0] = 1'b1;
    tick();
    chk("t1_evt_clr", 32'(evt_rise[0]), 32'd0);
    clr[0] = 1'b0;

    // 3-cycle glitch on pad 1 is rejected; 6-cycle pulse passes
    seen = '0;
    pad[1] = 1'b1;
    repeat (3) begin tick(); seen[0] |= filt[1] | rise[1] | fall[1]; end
    pad[1] = 1'b0;
    repeat (12) begin tick(); seen[0] |= filt[1] | rise[1] | fall[1]; end
    chk("t2_glitch", 32'(seen[0]), 32'd0);
    pad[1] = 1'b1;
    repeat (6) tick();
    pad[1] = 1'b0;
    tick();
    chk("t2_rise", 32'(rise[1]), 32'd1);
    repeat (5) tick();
    chk("t2_fall_early", 32'(fall[1]), 32'd0);
    tick();
    chk("t2_fall", 32'(fall[1]), 32'd1);

    // T=0: pad 2 toggles every 4 cycles, filt follows 3 edges later
    thresh = 8'd0; nr = 0; nf = 0;
    for (int k = 0; k < 28; k++) begin
      if (k % 4 == 0 && k <= 20) pad[2] = ~pad[2];
      hist.push_back(pad[2]);
      tick();
      nr += int'(rise[2]);
      nf += int'(fall[2]);
      if (hist.size() >= 3) chk("t3_delay", 32'(filt[2]), 32'(hist[hist.size()-3]));
    end
    chk("t3_rises", 32'(nr), 32'd3);
    chk("t3_falls", 32'(nf), 32'd3);

    // T=200: disable pad 3 mid-count, then re-enable and count afresh
    rst_n = 1'b0; pad = 4'b1000;
    tick();
    rst_n = 1'b1; thresh = 8'd200;
    repeat (102) tick();
    en[3] = 1'b0; seen = '0;
    repeat (5) begin tick(); seen[0] |= filt[3] | rise[3] | fall[3]; end
    chk("t4_disabled", 32'(seen[0]), 32'd0);
    en[3] = 1'b1;
    repeat (200) tick();
    chk("t4_filt_early", 32'(filt[3]), 32'd0);
    tick();
    chk("t4_filt", 32'(filt[3]), 32'd1);
    chk("t4_rise", 32'(rise[3]), 32'd1);

    // Reset mid-count clears everything; then same-cycle clear vs set
    thresh = 8'd4; pad = 4'b0111;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("t5_reset_outs", 32'({filt, rise, fall, evt_rise, evt_fall}), 32'd0);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("t5_filt_early", 32'(filt), 32'd0);
    tick();
    chk("t5_filt", 32'(filt), 32'b0111);
    chk("t5_rise", 32'(rise), 32'b0111);
    clr = 4'b1111;
    tick();
    chk("t5_set_wins", 32'(evt_rise), 32'b0111);
    clr = '0;

    // T=255: accepted after 258 edges
    rst_n = 1'b0; pad = 4'b1111;
    tick();
    rst_n = 1'b1; thresh = 8'd255;
    repeat (257) tick();
    chk("t6_filt_early", 32'(filt), 32'd0);
    tick();
    chk("t6_filt", 32'(filt), 32'hf);

    // Random traffic against the model
    for (int seg = 0; seg < 4; seg++) begin
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      thresh = 8'($urandom_range(0, 6));
      for (int c = 0; c < 300; c++) begin
        pad ^= 4'($urandom) & 4'($urandom);
        en   = ~(4'($urandom) & 4'($urandom) & 4'($urandom));
        clr  = 4'($urandom) & 4'($urandom) & 4'($urandom);
        tick();
      end
      en = '1; clr = '0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
